adder_mul_sequencer: RTL

Multi-cycle unsigned multiplier controller that sequences the shared ripple-carry adder (the `First_Input`/`Second_Input`/`Sub` datapath adder) through a shift-and-add algorithm. It produces an N×N→2N product in N adder passes. It sits beside the ALU and drives the adder's operand and `Sub` inputs through dedicated ports. It consumes the adder's sum and carry in the same cycle and holds the result until the next request.

---
 rtl/adder_mul_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/adder_mul_sequencer.sv
// Shift-and-add unsigned multiplier controller: steps an external N-bit ripple adder
// through N passes to form an N x N -> 2N product, then pulses Done for one cycle.
module adder_mul_sequencer #(
  parameter int N = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [N-1:0]   Multiplicand,
  input  logic [N-1:0]   Multiplier,
  output logic           Busy,
  output logic           Done,
  output logic [2*N-1:0] Product,
  output logic [N-1:0]   Adder_A,
  output logic [N-1:0]   Adder_B,
  output logic           Adder_Sub,
  input  logic [N-1:0]   Adder_Sum,
  input  logic           Adder_Carry
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   m_q, m_d;
  logic [2*N-1:0] p_q, p_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] product_q, product_d;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    count_d   = count_q;
    product_d = product_q;
    Adder_A   = '0;
    Adder_B   = '0;
    Busy      = 1'b0;
    Done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          m_d     = Multiplicand;
          p_d     = {{N{1'b0}}, Multiplier};
          count_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        Busy    = 1'b1;
        Adder_A = p_q[2*N-1:N];
        // A zero addend when the multiplier LSB is clear keeps the step uniform.
        Adder_B = p_q[0] ? m_q : '0;
        p_d     = {Adder_Carry, Adder_Sum, p_q[N-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          product_d = p_d;
          state_d   = DONE;
        end
      end

      DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign Adder_Sub = 1'b0;
  assign Product   = product_q;

endmodule
